// File: rtl/rca_mpadd_seq_if.sv
// Operand/result stream bundle for the multi-precision add/subtract sequencer.
// Latency: none (wires only); the sequencer registers the result side.
// Backpressure: in_ready/out_ready valid-ready handshakes; out_ovf present only with RCA_MPADD_SEQ_OVF_EN.
interface rca_mpadd_seq_if #(
  parameter int BITS = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_a;
  logic [BITS-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_sum;
  logic            out_last;
  logic            out_carry;
`ifdef RCA_MPADD_SEQ_OVF_EN
  logic            out_ovf;

  // Operand source / result sink side.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_carry, out_ovf
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_carry, out_ovf
  );
`else
  // Operand source / result sink side.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_carry
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_carry
  );
`endif
endinterface

// File: rtl/rca_mpadd_seq.sv
// Multi-precision add/subtract: WORDS word pairs (LS first) through one BITS-wide ripple-carry adder.
// Latency: 1 cycle from input handshake to out_valid; one word per cycle while out_ready stays high.
// Backpressure: a stalled output drops in_ready; optional out_ovf via macro RCA_MPADD_SEQ_OVF_EN.

// Plain ripple-carry adder; c_msb is the carry into the top bit, used for signed overflow.
module rca #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            c_in,
  output logic [BITS-1:0] sum,
  output logic            c_msb,
  output logic            c_out
);
  // Bit-serial carry chain, LSB to MSB.
  always_comb begin
    logic cy;
    cy    = c_in;
    c_msb = 1'b0;
    sum   = '0;
    for (int i = 0; i < BITS; i++) begin
      if (i == BITS - 1) c_msb = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end
endmodule

module rca_mpadd_seq #(
  parameter int BITS  = 32,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  output logic                busy,
  output logic                done,
  rca_mpadd_seq_if.slave      bus
);
  localparam int CW = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            sub_q;
  logic            carry_q;
  logic            out_valid_q;
  logic [BITS-1:0] out_sum_q;
  logic            out_last_q;
  logic            out_carry_q;
  logic            done_q;

  logic [BITS-1:0] b_eff;
  logic [BITS-1:0] add_sum;
  logic            add_c_msb;
  logic            add_c_out;
  logic            in_fire;
  logic            out_fire;
  logic            is_last;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry_q.
  assign b_eff    = sub_q ? ~bus.in_b : bus.in_b;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = out_valid_q && bus.out_ready;
  assign is_last  = (cnt_q == LAST_IDX);

  rca #(.BITS(BITS)) u_rca (
    .a     (bus.in_a),
    .b     (b_eff),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_msb (add_c_msb),
    .c_out (add_c_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                   state_d = RUN;
      RUN:     if (in_fire && is_last)      state_d = DRAIN;
      DRAIN:   if (out_fire && out_last_q)  state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // State-derived outputs: busy flag and input acceptance.
  always_comb begin
    busy         = (state_q != IDLE);
    bus.in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  end

  // Carry chain, word counter and registered result stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        sub_q   <= sub;
        carry_q <= sub;
        cnt_q   <= '0;
      end
      if (in_fire) begin
        out_sum_q   <= add_sum;
        out_valid_q <= 1'b1;
        out_last_q  <= is_last;
        carry_q     <= add_c_out;
        out_carry_q <= add_c_out;
        cnt_q       <= cnt_q + 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      done_q <= (state_q == DRAIN) && out_fire && out_last_q;
    end
  end

`ifdef RCA_MPADD_SEQ_OVF_EN
  logic out_ovf_q;

  // Signed overflow only means something on the most significant word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_ovf_q <= 1'b0;
    else if (in_fire) out_ovf_q <= is_last ? (add_c_msb ^ add_c_out) : 1'b0;
  end

  assign bus.out_ovf = out_ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = add_c_msb;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_carry = out_carry_q;
  assign done          = done_q;
endmodule

// File: tb/tb_rca_mpadd_seq.sv
// Directed bench: a 4-word and a 1-word instance (8-bit words) share clock and reset.
// Latency: inputs are driven and outputs sampled on the falling clock edge.
// Backpressure: exercises output stalls, ignored starts/inputs and mid-operation reset.
module tb_rca_mpadd_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic start4, sub4, busy4, done4;
  logic start1, sub1, busy1, done1;
  int   ncmp  = 0;
  int   nfail = 0;

  rca_mpadd_seq_if #(.BITS(8)) if4 ();
  rca_mpadd_seq_if #(.BITS(8)) if1 ();

  rca_mpadd_seq #(.BITS(8), .WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
    .busy(busy4), .done(done4), .bus(if4)
  );

  rca_mpadd_seq #(.BITS(8), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
    .busy(busy1), .done(done1), .bus(if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full 4-word operation with the sink always ready; res/cy/ov are hand-computed.
  task automatic op4(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic cy, input logic ov);
    start4 = 1'b1; sub4 = s; if4.out_ready = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk({tag, ":busy"}, busy4, 1);
    for (int w = 0; w < 4; w++) begin
      if4.in_valid = 1'b1; if4.in_a = a[8*w +: 8]; if4.in_b = b[8*w +: 8];
      #1 chk({tag, ":in_ready"}, if4.in_ready, 1);
      @(negedge clk);
      chk({tag, ":valid"}, if4.out_valid, 1);
      chk({tag, ":sum"}, if4.out_sum, res[8*w +: 8]);
      chk({tag, ":last"}, if4.out_last, (w == 3) ? 1 : 0);
    end
    if4.in_valid = 1'b0;
    chk({tag, ":carry"}, if4.out_carry, cy);
`ifdef RCA_MPADD_SEQ_OVF_EN
    chk({tag, ":ovf"}, if4.out_ovf, ov);
`else
    if (ov !== ov) chk({tag, ":ovf_x"}, 0, 1);
`endif
    chk({tag, ":drain_ready"}, if4.in_ready, 0);
    @(negedge clk);
    chk({tag, ":done"}, done4, 1);
    chk({tag, ":idle"}, busy4, 0);
    chk({tag, ":valid_clr"}, if4.out_valid, 0);
    @(negedge clk);
    chk({tag, ":done_once"}, done4, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; start1 = 1'b0; sub1 = 1'b0;
    if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst:busy", busy4, 0);
    chk("rst:in_ready", if4.in_ready, 0);
    chk("rst:out_valid", if4.out_valid, 0);
    chk("rst:out_sum", if4.out_sum, 0);
    chk("rst:out_last", if4.out_last, 0);
    chk("rst:out_carry", if4.out_carry, 0);
    chk("rst:done", done4, 0);
    chk("rst1:busy", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: add with carry rippling through three words.
    op4("t1", 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0);
    // 2: subtract producing a borrow.
    op4("t2", 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // 3: output stalled for 3 cycles after the first word.
    start4 = 1'b1; sub4 = 1'b0; if4.out_ready = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    if4.in_valid = 1'b1; if4.in_a = 8'hFF; if4.in_b = 8'h01;
    @(negedge clk);
    chk("t3:w0_sum", if4.out_sum, 8'h00);
    if4.out_ready = 1'b0; if4.in_a = 8'hFF; if4.in_b = 8'h00;
    #1 chk("t3:stall_ready", if4.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3:stall_ready_hold", if4.in_ready, 0);
      chk("t3:stall_valid", if4.out_valid, 1);
      chk("t3:stall_sum", if4.out_sum, 8'h00);
      chk("t3:stall_last", if4.out_last, 0);
    end
    if4.out_ready = 1'b1;
    #1 chk("t3:resume_ready", if4.in_ready, 1);
    for (int w = 1; w < 4; w++) begin
      @(negedge clk);
      chk("t3:sum", if4.out_sum, 8'h00);
      chk("t3:last", if4.out_last, (w == 3) ? 1 : 0);
    end
    if4.in_valid = 1'b0;
    chk("t3:carry", if4.out_carry, 1);
    @(negedge clk);
    chk("t3:done", done4, 1);
    @(negedge clk);
    chk("t3:done_once", done4, 0);

    // 4: signed overflow into the sign bit.
    op4("t4", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);

    // 5: single-word instance, start held high, early input ignored.
    if1.in_valid = 1'b1; if1.in_a = 8'h10; if1.in_b = 8'h20;
    @(negedge clk);
    chk("t5:idle_ready", if1.in_ready, 0);
    @(negedge clk);
    chk("t5:idle_valid", if1.out_valid, 0);
    start1 = 1'b1; sub1 = 1'b0; if1.out_ready = 1'b0;
    if1.in_a = 8'h12; if1.in_b = 8'h34;
    @(negedge clk);
    chk("t5:busy", busy1, 1);
    chk("t5:run_ready", if1.in_ready, 1);
    @(negedge clk);
    chk("t5:sum", if1.out_sum, 8'h46);
    chk("t5:last", if1.out_last, 1);
    chk("t5:drain_ready", if1.in_ready, 0);
    @(negedge clk);
    chk("t5:drain_hold", busy1, 1);
    chk("t5:drain_valid", if1.out_valid, 1);
    if1.out_ready = 1'b1;
    @(negedge clk);
    chk("t5:start_ignored", busy1, 0);
    chk("t5:done", done1, 1);
    chk("t5:valid_clr", if1.out_valid, 0);
    if1.in_a = 8'h01; if1.in_b = 8'h02;
    @(negedge clk);
    chk("t5:op2_busy", busy1, 1);
    chk("t5:op2_done_low", done1, 0);
    @(negedge clk);
    chk("t5:op2_sum", if1.out_sum, 8'h03);
    chk("t5:op2_valid", if1.out_valid, 1);
    start1 = 1'b0; if1.in_valid = 1'b0;
    @(negedge clk);
    chk("t5:op2_done", done1, 1);
    chk("t5:op2_idle", busy1, 0);
    @(negedge clk);
    chk("t5:op2_valid_clr", if1.out_valid, 0);
    chk("t5:no_restart", busy1, 0);

    // 6: reset after the second input word, then a clean operation.
    start4 = 1'b1; sub4 = 1'b0; if4.out_ready = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    if4.in_valid = 1'b1; if4.in_a = 8'hFF; if4.in_b = 8'hFF;
    @(negedge clk);
    chk("t6:w0_sum", if4.out_sum, 8'hFE);
    if4.in_a = 8'hFF; if4.in_b = 8'h01;
    @(negedge clk);
    chk("t6:w1_sum", if4.out_sum, 8'h01);
    chk("t6:w1_carry", if4.out_carry, 1);
    if4.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6:rst_busy", busy4, 0);
    chk("t6:rst_in_ready", if4.in_ready, 0);
    chk("t6:rst_valid", if4.out_valid, 0);
    chk("t6:rst_sum", if4.out_sum, 0);
    chk("t6:rst_carry", if4.out_carry, 0);
    chk("t6:rst_done", done4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op4("t6b", 1'b0, 32'h0102_0304, 32'h0101_0101, 32'h0203_0405, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/rca_mpadd_seq.md
Name: rca_mpadd_seq

Overview:
Multi-precision add/subtract sequencer built around one BITS-wide ripple-carry adder (`rca` instance).
- Takes WORDS operand word-pairs, least significant first, over a valid/ready stream.
- Chains the carry between words through a carry register.
- Emits one sum word per input word on a registered valid/ready output stream.
- Sits between an operand source (bus master / DMA) and a result sink, so one narrow adder serves wide integer operations.

Parameters:
BITS, 32, width of one word and of the internal adder.
WORDS, 4, words per operation; legal range 1..256.

Ports:
_clk  in  1  clock, rising edge.
_rst_n  in  1  asynchronous active-low reset.
_start  in  1  begin operation; sampled only in IDLE.
_sub  in  1  mode latched with _start: 0 = A+B, 1 = A-B.
_busy  out  1  high in any state other than IDLE.
_in_valid  in  1  operand word pair valid.
_in_ready  out  1  block accepts operand word pair.
_in_a  in  BITS  operand A word.
_in_b  in  BITS  operand B word.
_out_valid  out  1  result word valid.
_out_ready  in  1  sink accepts result word.
_out_sum  out  BITS  result word.
_out_last  out  1  marks the final (most significant) result word.
_out_carry  out  1  final carry out; meaningful only when _out_valid && _out_last.
_done  out  1  one-cycle pulse when the last result word is accepted.

Behaviour:
Reset (async assert, sync release to internal logic):
- State IDLE; carry register 0; word counter 0.
- Outputs 0: _busy, _in_ready, _out_valid, _out_sum, _out_last, _out_carry, _done.

States:
- IDLE -> RUN on _start; latch _sub; carry_reg <= _sub; counter <= 0.
- RUN -> DRAIN when the input handshake with counter == WORDS-1 completes.
- DRAIN -> IDLE when the last output word handshake completes; _done pulses that same cycle (registered, visible next cycle).
- _start is ignored outside IDLE.

Datapath:
- Adder inputs: a = _in_a, b = _sub ? ~_in_b : _in_b, c_in = carry_reg.

Input handshake (RUN only):
- _in_ready = (state==RUN) && (!_out_valid || _out_ready).
- On _in_valid && _in_ready, in the same edge:
  - _out_sum <= adder sum.
  - _out_valid <= 1.
  - _out_last <= (counter==WORDS-1).
  - carry_reg <= adder c_out.
  - _out_carry <= adder c_out.
  - counter++.
- Latency: 1 cycle, input handshake to _out_valid.
- Full throughput: one word per cycle while _out_ready stays high.

Output handshake:
- _out_valid && _out_ready clears _out_valid, unless a new word loads the same cycle.
- Output payload holds stable while _out_valid && !_out_ready.
- A stalled output deasserts _in_ready; no input word is lost.

Boundary conditions:
- WORDS=1: RUN -> DRAIN after the first word.
- _in_valid in IDLE/DRAIN: ignored; _in_ready stays 0.
- Simultaneous last-word output accept and _start: _start is ignored (state still DRAIN).
- _out_carry in subtract mode = no-borrow flag (1 means A >= B, unsigned).
- Reset mid-operation: immediate abort to reset values; partial results are discarded.
- Counter width: clog2(WORDS)+1 bits; no wrap inside an operation.

Optional Feature:
Macro RCA_MPADD_SEQ_OVF_EN.
- Defined: adds output _out_ovf (1 bit), registered with the last word.
  - _out_ovf = signed overflow of the full-width operation = carry into MSB XOR carry out of MSB of the last word, using effective (possibly inverted) b.
  - Held with the payload; 0 on non-last words and at reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. BITS=8, WORDS=4, add, A=0x00FFFFFF, B=0x00000001 -> sums 0x00,0x00,0x00,0x01; carry 0; _out_last only on 4th word; _done pulses once.
2. Subtract, A=0x00000005, B=0x00000007 -> sums 0xFE,0xFF,0xFF,0xFF; _out_carry=0; with OVF_EN _out_ovf=0.
3. Add, A=0xFFFFFFFF, B=0x00000001, _out_ready held low 3 cycles after first word -> _in_ready low during stall; payload 0x00 stable; final _out_carry=1.
4. OVF_EN: add A=0x7FFFFFFF, B=0x00000001 -> last word 0x80; _out_ovf=1; _out_carry=0.
5. WORDS=1, _start asserted every cycle, plus _in_valid before _start -> early word ignored; exactly one result per operation; _start during RUN/DRAIN ignored.
6. Assert _rst_n low after the 2nd input word -> all outputs 0 asynchronously; next operation add 0x01020304 + 0x01010101 gives 0x05,0x04,0x03,0x02.
